// File: rtl/sr_reg_bank_pkg.sv
// Shared definitions for the SR register bank: conflict-resolution modes,
// the per-bit next-state function, and a few derived constants.
package sr_pkg;

    // Behaviour selected when set and reset are requested together
    localparam int SR_SET_DOM = 0;
    localparam int SR_RST_DOM = 1;
    localparam int SR_TOGGLE  = 2;
    localparam int SR_HOLD    = 3;

    typedef enum logic [1:0] {
        MODE_SET_DOM = 2'd0,
        MODE_RST_DOM = 2'd1,
        MODE_TOGGLE  = 2'd2,
        MODE_HOLD    = 2'd3
    } sr_mode_e;

    // Next state of a single SR cell. A 0/0 request always holds; the 1/1
    // request is resolved by mode, so no input combination yields X.
    function automatic logic sr_next(input logic [1:0] mode, input logic s,
                                     input logic r, input logic q);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b00: nxt = q;
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            default: begin
                case (sr_mode_e'(mode))
                    MODE_SET_DOM: nxt = 1'b1;
                    MODE_RST_DOM: nxt = 1'b0;
                    MODE_TOGGLE:  nxt = ~q;
                    default:      nxt = q;
                endcase
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_reg_bank_sync.sv
// Input synchroniser: STAGES flops of WIDTH bits, no enable. STAGES=0
// collapses to a wire so the cell sees the raw request.
module sr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES == 0) begin : g_pass
            assign q = d;
        end else begin : g_flops
            logic [STAGES-1:0][WIDTH-1:0] pipe;

            // Shift the request through the stage chain; reset discards
            // anything in flight.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe <= '0;
                end else begin
                    pipe[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign q = pipe[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sr_reg_bank.sv
// Clocked bank of SR storage cells with selectable 1/1 resolution, optional
// request synchroniser, per-channel change pulses and sticky conflict
// reporting with a saturating cycle counter.
module sr_reg_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               MODE        = SR_SET_DOM,
    parameter int               SYNC_STAGES = 0,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [1:0]       MODE_SEL = 2'(MODE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] ss;
    logic [WIDTH-1:0] rr;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] hit;
    logic             any_hit;

    sr_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_s (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (s),
        .q     (ss)
    );

    sr_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_r (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (r),
        .q     (rr)
    );

    // Next state per channel; en is sampled raw so it gates whatever ss/rr
    // are present at this edge.
    always_comb begin
        q_nxt = q;
        hit   = ss & rr & {WIDTH{en}};
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                q_nxt[i] = sr_next(MODE_SEL, ss[i], rr[i], q[i]);
            end
        end
        any_hit = |hit;
    end

    // Cell state and change pulse registered together so they line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= RESET_VAL;
            changed <= '0;
        end else begin
            q       <= q_nxt;
            changed <= q_nxt ^ q;
        end
    end

    // Sticky conflict flags and saturating count of conflict cycles. A clear
    // that coincides with a new conflict keeps only the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict     <= '0;
            conflict_cnt <= '0;
        end else if (clr_conflict) begin
            conflict     <= hit;
            conflict_cnt <= any_hit ? CNT_ONE : '0;
        end else begin
            conflict <= conflict | hit;
            if (any_hit && conflict_cnt != CNT_MAX) begin
                conflict_cnt <= conflict_cnt + CNT_ONE;
            end
        end
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Scoreboard bench for sr_reg_bank. Four instances cover set-dominant,
// reset-dominant, toggle with a 2-bit counter, and a 2-stage synchroniser.
module tb_sr_reg_bank;
    import sr_pkg::*;

    typedef struct {
        int         id;
        int         due;
        logic [3:0] q;
        logic [3:0] ch;
        logic [3:0] cf;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [3:0] s_i[4];
    logic [3:0] r_i[4];
    logic       en_i[4];
    logic       clr_i[4];
    logic [3:0] q_o[4];
    logic [3:0] qn_o[4];
    logic [3:0] ch_o[4];
    logic [3:0] cf_o[4];
    logic [7:0] cnt_o[4];
    logic [7:0] cnt_a, cnt_b, cnt_d;
    logic [1:0] cnt_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sr_reg_bank #(.WIDTH(4), .MODE(SR_SET_DOM), .SYNC_STAGES(0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_i[0]), .s(s_i[0]), .r(r_i[0]),
        .clr_conflict(clr_i[0]), .q(q_o[0]), .q_n(qn_o[0]), .changed(ch_o[0]),
        .conflict(cf_o[0]), .conflict_cnt(cnt_a));
    sr_reg_bank #(.WIDTH(4), .MODE(SR_RST_DOM), .SYNC_STAGES(0), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_i[1]), .s(s_i[1]), .r(r_i[1]),
        .clr_conflict(clr_i[1]), .q(q_o[1]), .q_n(qn_o[1]), .changed(ch_o[1]),
        .conflict(cf_o[1]), .conflict_cnt(cnt_b));
    sr_reg_bank #(.WIDTH(4), .MODE(SR_TOGGLE), .SYNC_STAGES(0), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en_i[2]), .s(s_i[2]), .r(r_i[2]),
        .clr_conflict(clr_i[2]), .q(q_o[2]), .q_n(qn_o[2]), .changed(ch_o[2]),
        .conflict(cf_o[2]), .conflict_cnt(cnt_c));
    sr_reg_bank #(.WIDTH(4), .MODE(SR_SET_DOM), .SYNC_STAGES(2), .CNT_W(8)) u_d (
        .clk(clk), .rst_n(rst_n), .en(en_i[3]), .s(s_i[3]), .r(r_i[3]),
        .clr_conflict(clr_i[3]), .q(q_o[3]), .q_n(qn_o[3]), .changed(ch_o[3]),
        .conflict(cf_o[3]), .conflict_cnt(cnt_d));

    assign cnt_o[0] = cnt_a;
    assign cnt_o[1] = cnt_b;
    assign cnt_o[2] = {6'b0, cnt_c};
    assign cnt_o[3] = cnt_d;

    task automatic push(input int id, input int due, input logic [3:0] q,
                        input logic [3:0] ch, input logic [3:0] cf,
                        input logic [7:0] cnt, input string name);
        exp_t e;
        e.id = id; e.due = due; e.q = q; e.ch = ch; e.cf = cf; e.cnt = cnt;
        e.name = name;
        sb.push_back(e);
    endtask

    // Expected outputs after the next rising edge
    task automatic chk(input int id, input logic [3:0] q, input logic [3:0] ch,
                       input logic [3:0] cf, input logic [7:0] cnt, input string name);
        push(id, cyc + 1, q, ch, cf, cnt, name);
    endtask

    task automatic drv(input int id, input logic [3:0] s, input logic [3:0] r,
                       input logic en, input logic clr);
        s_i[id] = s; r_i[id] = r; en_i[id] = en; clr_i[id] = clr;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: compare every due expectation at the falling edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            int   id;
            e = sb.pop_front();
            id = e.id;
            checks++;
            if (e.due != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d checked at %0d", e.name, e.due, cyc);
            end else if (q_o[id] !== e.q || qn_o[id] !== ~e.q || ch_o[id] !== e.ch ||
                         cf_o[id] !== e.cf || cnt_o[id] !== e.cnt) begin
                errors++;
                $display("FAIL %s: got q=%b q_n=%b ch=%b cf=%b cnt=%0d want q=%b q_n=%b ch=%b cf=%b cnt=%0d",
                         e.name, q_o[id], qn_o[id], ch_o[id], cf_o[id], cnt_o[id],
                         e.q, ~e.q, e.ch, e.cf, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) drv(i, 4'b0, 4'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state of every instance
        for (int i = 0; i < 4; i++) chk(i, 4'b0, 4'b0, 4'b0, 8'd0, "reset_state");
        tick();

        // Set-dominant bank: basic set/hold/reset, conflict, clear interplay
        drv(0, 4'b0101, 4'b0000, 1, 0); chk(0, 4'b0101, 4'b0101, 4'b0000, 0, "a_set");     tick();
        drv(0, 4'b0000, 4'b0000, 1, 0); chk(0, 4'b0101, 4'b0000, 4'b0000, 0, "a_hold");    tick();
        drv(0, 4'b0000, 4'b0100, 1, 0); chk(0, 4'b0001, 4'b0100, 4'b0000, 0, "a_rst");     tick();
        drv(0, 4'b0001, 4'b0001, 1, 0); chk(0, 4'b0001, 4'b0000, 4'b0001, 1, "a_setdom");  tick();
        drv(0, 4'b0100, 4'b0100, 1, 1); chk(0, 4'b0101, 4'b0100, 4'b0100, 1, "a_clr_new"); tick();
        drv(0, 4'b0000, 4'b0000, 1, 1); chk(0, 4'b0101, 4'b0000, 4'b0000, 0, "a_clr");     tick();
        drv(0, 4'b0010, 4'b0010, 0, 0); chk(0, 4'b0101, 4'b0000, 4'b0000, 0, "a_en0");     tick();
        drv(0, 4'b0010, 4'b0010, 1, 0); chk(0, 4'b0111, 4'b0010, 4'b0010, 1, "a_cf1");     tick();
        drv(0, 4'b0010, 4'b0010, 1, 0); chk(0, 4'b0111, 4'b0000, 4'b0010, 2, "a_cf2");     tick();
        drv(0, 4'b0000, 4'b0000, 0, 0);

        // Reset-dominant bank, then clear with en low
        drv(1, 4'b0011, 4'b0000, 1, 0); chk(1, 4'b0011, 4'b0011, 4'b0000, 0, "b_set");     tick();
        drv(1, 4'b0011, 4'b0011, 1, 0); chk(1, 4'b0000, 4'b0011, 4'b0011, 1, "b_rstdom");  tick();
        drv(1, 4'b1111, 4'b0000, 0, 0); chk(1, 4'b0000, 4'b0000, 4'b0011, 1, "b_en0");     tick();
        drv(1, 4'b0000, 4'b0000, 0, 1); chk(1, 4'b0000, 4'b0000, 4'b0000, 0, "b_clr_en0"); tick();
        drv(1, 4'b0000, 4'b0000, 0, 0);

        // Toggle bank, 2-bit counter saturates at 3
        drv(2, 4'b1111, 4'b1111, 1, 0); chk(2, 4'b1111, 4'b1111, 4'b1111, 1, "c_tog1"); tick();
        chk(2, 4'b0000, 4'b1111, 4'b1111, 2, "c_tog2"); tick();
        chk(2, 4'b1111, 4'b1111, 4'b1111, 3, "c_tog3"); tick();
        chk(2, 4'b0000, 4'b1111, 4'b1111, 3, "c_sat4"); tick();
        chk(2, 4'b1111, 4'b1111, 4'b1111, 3, "c_sat5"); tick();
        chk(2, 4'b0000, 4'b1111, 4'b1111, 3, "c_sat6"); tick();

        // Synchronised bank: pulse driven after edge k reaches q at edge k+3
        drv(3, 4'b0001, 4'b0000, 1, 0); chk(3, 4'b0000, 4'b0000, 4'b0000, 0, "d_k1"); tick();
        drv(3, 4'b0000, 4'b0000, 1, 0); chk(3, 4'b0000, 4'b0000, 4'b0000, 0, "d_k2"); tick();
        chk(3, 4'b0001, 4'b0001, 4'b0000, 0, "d_k3"); tick();
        chk(3, 4'b0001, 4'b0000, 4'b0000, 0, "d_k4"); tick();
        // Same pulse with en low across the whole window
        drv(3, 4'b0010, 4'b0000, 0, 0); chk(3, 4'b0001, 4'b0000, 4'b0000, 0, "d_en0_1"); tick();
        drv(3, 4'b0000, 4'b0000, 0, 0); chk(3, 4'b0001, 4'b0000, 4'b0000, 0, "d_en0_2"); tick();
        chk(3, 4'b0001, 4'b0000, 4'b0000, 0, "d_en0_3"); tick();
        chk(3, 4'b0001, 4'b0000, 4'b0000, 0, "d_en0_4"); tick();
        drv(3, 4'b0000, 4'b0000, 1, 0); chk(3, 4'b0001, 4'b0000, 4'b0000, 0, "d_en1_idle"); tick();

        // Asynchronous reset between edges while the toggle bank runs
        @(posedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) push(i, cyc, 4'b0, 4'b0, 4'b0, 8'd0, "mid_reset");
        tick();
        rst_n = 1'b1;
        chk(2, 4'b1111, 4'b1111, 4'b1111, 1, "c_release"); tick();

        repeat (2) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
